// File: rtl/player_input_ctrl.sv
// player_input_ctrl
// Turns the five raw push-buttons into clean game commands. Each button is
// synchronised (2 FF) and debounced. The debounced direction buttons are
// priority-encoded (U > D > L > R) into one move command with a valid/ready
// handshake. Each debounced press of S produces a one-cycle bomb request.
//
// Optional feature: define INPUT_AUTOREPEAT_EN to re-issue the held direction
// every REPEAT_CYCLES cycles. Without it, one move is issued per change of the
// active direction and REPEAT_CYCLES is unused.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   btn_u_i..btn_s_i  raw asynchronous buttons, active-high
//   cmd_valid_o  move command pending
//   cmd_dir_o    00=up 01=down 10=left 11=right, stable while cmd_valid_o
//   cmd_ready_i  consumer accepts the move when high with cmd_valid_o
//   bomb_req_o   one-cycle pulse per debounced btn_s press
//   btn_db_o     debounced levels {S,R,L,D,U}
module player_input_ctrl #(
    parameter int unsigned DEB_CYCLES    = 10000,
    parameter int unsigned REPEAT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_u_i,
    input  logic       btn_d_i,
    input  logic       btn_l_i,
    input  logic       btn_r_i,
    input  logic       btn_s_i,
    output logic       cmd_valid_o,
    output logic [1:0] cmd_dir_o,
    input  logic       cmd_ready_i,
    output logic       bomb_req_o,
    output logic [4:0] btn_db_o
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES) + 1;

    typedef enum logic {StIdle, StHeld} state_e;

    logic [4:0]      raw;
    logic [4:0]      sync1_q, sync2_q;
    logic [4:0]      db_q, db_d;
    logic [CntW-1:0] cnt_q [5];
    logic [CntW-1:0] cnt_d [5];

    state_e          state_q, state_d;
    logic [1:0]      dir_q, dir_d;
    logic            dir_any;
    logic [1:0]      dir_act;
    logic            issue;

    logic            cmd_valid_q, cmd_valid_d;
    logic [1:0]      cmd_dir_q, cmd_dir_d;
    logic            s_prev_q;
    logic            bomb_req_q, bomb_req_d;

`ifdef INPUT_AUTOREPEAT_EN
    localparam int unsigned TimW = $clog2(REPEAT_CYCLES);
    logic [TimW-1:0] timer_q, timer_d;
`else
    // REPEAT_CYCLES only matters when auto-repeat is built in.
    if (REPEAT_CYCLES < 2) begin : gen_repeat_unused
    end
`endif

    assign raw = {btn_s_i, btn_r_i, btn_l_i, btn_d_i, btn_u_i};

    // Debounce: count consecutive cycles where the synced level disagrees
    // with the accepted level; flip once the disagreement lasted DEB_CYCLES.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntW'(DEB_CYCLES - 1)) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Priority encode U > D > L > R.
    always_comb begin
        dir_any = |db_q[3:0];
        if (db_q[0])      dir_act = 2'b00;
        else if (db_q[1]) dir_act = 2'b01;
        else if (db_q[2]) dir_act = 2'b10;
        else              dir_act = 2'b11;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        issue   = 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
        timer_d = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (dir_any) begin
                    issue   = 1'b1;
                    state_d = StHeld;
                    dir_d   = dir_act;
                end
            end
            StHeld: begin
                if (!dir_any) begin
                    state_d = StIdle;
                end else if (dir_act != dir_q) begin
                    issue = 1'b1;
                    dir_d = dir_act;
`ifdef INPUT_AUTOREPEAT_EN
                end else if (timer_q == TimW'(REPEAT_CYCLES - 1)) begin
                    issue = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An issue while a command is still pending is dropped, unless that
    // command is being accepted on this same edge.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_dir_d   = cmd_dir_q;
        if (cmd_valid_q && cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end
        if (issue && (!cmd_valid_q || cmd_ready_i)) begin
            cmd_valid_d = 1'b1;
            cmd_dir_d   = dir_act;
        end
        bomb_req_d = db_q[4] & ~s_prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            state_q     <= StIdle;
            dir_q       <= 2'b00;
            cmd_valid_q <= 1'b0;
            cmd_dir_q   <= 2'b00;
            s_prev_q    <= 1'b0;
            bomb_req_q  <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
            timer_q     <= '0;
`endif
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            state_q     <= state_d;
            dir_q       <= dir_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_dir_q   <= cmd_dir_d;
            s_prev_q    <= db_q[4];
            bomb_req_q  <= bomb_req_d;
`ifdef INPUT_AUTOREPEAT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_dir_o   = cmd_dir_q;
    assign bomb_req_o  = bomb_req_q;
    assign btn_db_o    = db_q;

endmodule
